sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DSIZE, default 8, data word width in bits (>=1).
REQ-002 Parameter ASIZE, default 4, address width; DEPTH = 2**ASIZE words (ASIZE>=1).
REQ-003 Parameter AF_LEVEL, default 14, almost-full threshold in words (1..DEPTH).
REQ-004 Parameter AE_LEVEL, default 2, almost-empty threshold in words (0..DEPTH-1).
REQ-005 Parameter FWFT, default 1, read mode: 1 = first-word-fall-through, 0 = registered read.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  input  1  sole clock, all state updates on rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 wr_data  input  DSIZE  write word.
REQ-010 wr_inc  input  1  write request.
REQ-011 rd_inc  input  1  read request.
REQ-012 err_clr  input  1  clears sticky error flags.
REQ-013 rd_data  output  DSIZE  read word.
REQ-014 rd_valid  output  1  rd_data holds a valid word.
REQ-015 wr_full  output  1  fill_cnt == DEPTH.
REQ-016 rd_empty  output  1  fill_cnt == 0.
REQ-017 wr_almost_full  output  1  fill_cnt >= AF_LEVEL.
REQ-018 rd_almost_empty  output  1  fill_cnt <= AE_LEVEL.
REQ-019 fill_cnt  output  ASIZE+1  words currently stored.
REQ-020 overflow  output  1  sticky: write requested while full.
REQ-021 underflow  output  1  sticky: read requested while empty.

Function
REQ-022 Write accepted iff wr_inc && !wr_full; word stored at wr_ptr[ASIZE-1:0]; wr_ptr (ASIZE+1 bits) increments, wrapping modulo 2**(ASIZE+1).
REQ-023 Read accepted iff rd_inc && !rd_empty; rd_ptr (ASIZE+1 bits) increments with the same wrap.
REQ-024 Full/empty are evaluated on pre-edge state: no write pass-through when full, no read bypass when empty, even if the opposite port is active in the same cycle.
REQ-025 fill_cnt: +1 on write only, -1 on read only, unchanged on both or neither; never exceeds DEPTH or goes below 0.
REQ-026 All flags are registered or derived from registered fill_cnt; a write is visible (rd_empty=0) the cycle after its accepting edge.
REQ-027 FWFT=1: rd_data = mem[rd_ptr[ASIZE-1:0]] combinationally; rd_valid = !rd_empty; rd_data undefined while empty.
REQ-028 FWFT=0: on an accepted read, rd_data registers mem[rd_ptr] and rd_valid = 1 for exactly the following cycle; rd_data otherwise holds its last value.
REQ-029 overflow sets on wr_inc && wr_full; underflow sets on rd_inc && rd_empty; both hold until err_clr or rst.
REQ-030 err_clr clears both sticky flags next edge; a same-cycle set event takes priority over err_clr.
REQ-031 Rejected requests do not change pointers, memory, fill_cnt or rd_data.
REQ-032 Pointer wrap after 2**(ASIZE+1) transfers is transparent: flags and data order are unaffected.

Reset
REQ-033 With rst high at an edge: wr_ptr=rd_ptr=0, fill_cnt=0, rd_empty=1, wr_full=0, rd_almost_empty=1, wr_almost_full=0, overflow=underflow=0, rd_valid=0, rd_data=0 (FWFT=0).
REQ-034 rst overrides wr_inc/rd_inc/err_clr in the same cycle; stored contents are discarded; memory array is not cleared.
REQ-035 Reset asserted mid-operation yields the REQ-033 state on the next edge; first accepted write after release goes to address 0.

Verification (DSIZE=8, ASIZE=4, AF_LEVEL=14, AE_LEVEL=2)
REQ-036 Reset, then 16 writes 0x00..0x0F -> wr_almost_full=1 at fill_cnt=14, wr_full=1 at 16; a 17th write sets overflow=1 and fill_cnt stays 16.
REQ-037 From full, 16 reads -> data 0x00..0x0F in order (FWFT=1 same cycle, FWFT=0 one cycle later with rd_valid pulse); rd_almost_empty=1 at fill_cnt=2; rd_empty=1 at 0; 17th read sets underflow=1.
REQ-038 Simultaneous wr_inc/rd_inc with fill_cnt=5 for 40 cycles -> fill_cnt stays 5, data in order across pointer wrap.
REQ-039 Empty FIFO, wr_inc and rd_inc together -> write accepted, read rejected, underflow=1, fill_cnt=1 next cycle; full FIFO, both together -> read accepted, write rejected, overflow=1, fill_cnt=15.
REQ-040 err_clr pulse with no error event -> overflow/underflow 0 next cycle; err_clr coincident with full-write -> overflow stays 1.
REQ-041 rst asserted at fill_cnt=9 -> next cycle fill_cnt=0, rd_empty=1, flags cleared; subsequent write 0xA5 read back as 0xA5.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO with count-derived status flags, sticky overflow/underflow
// errors and a selectable first-word-fall-through or registered read port.
module sync_fifo #(
    parameter int DSIZE    = 8,
    parameter int ASIZE    = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DSIZE-1:0] wr_data,
    input  logic             wr_inc,
    input  logic             rd_inc,
    input  logic             err_clr,
    output logic [DSIZE-1:0] rd_data,
    output logic             rd_valid,
    output logic             wr_full,
    output logic             rd_empty,
    output logic             wr_almost_full,
    output logic             rd_almost_empty,
    output logic [ASIZE:0]   fill_cnt,
    output logic             overflow,
    output logic             underflow
);

    localparam int             DEPTH    = 2 ** ASIZE;
    localparam logic [ASIZE:0] CNT_FULL = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] CNT_AF   = (ASIZE+1)'(AF_LEVEL);
    localparam logic [ASIZE:0] CNT_AE   = (ASIZE+1)'(AE_LEVEL);
    localparam logic [ASIZE:0] CNT_ONE  = (ASIZE+1)'(1);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [ASIZE:0]   wr_ptr;
    logic [ASIZE:0]   rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // Acceptance uses the flags as they stand before the edge, so a full FIFO
    // never passes a write through and an empty one never bypasses a read.
    assign wr_ok = wr_inc && !wr_full;
    assign rd_ok = rd_inc && !rd_empty;

    assign wr_full         = (fill_cnt == CNT_FULL);
    assign rd_empty        = (fill_cnt == '0);
    assign wr_almost_full  = (fill_cnt >= CNT_AF);
    assign rd_almost_empty = (fill_cnt <= CNT_AE);

    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill_cnt <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + CNT_ONE;
            if (rd_ok) rd_ptr <= rd_ptr + CNT_ONE;
            case ({wr_ok, rd_ok})
                2'b10:   fill_cnt <= fill_cnt + CNT_ONE;
                2'b01:   fill_cnt <= fill_cnt - CNT_ONE;
                default: fill_cnt <= fill_cnt;
            endcase
        end
    end

    // NOTE: the storage array has no reset; clearing it would cost a mux per
    // bit and the pointers already make stale contents unreachable.
    always_ff @(posedge clk) begin
        if (wr_ok && !rst) mem[wr_ptr[ASIZE-1:0]] <= wr_data;
    end

    // A set event in the same cycle wins over err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_inc && wr_full) overflow <= 1'b1;
            else if (err_clr)      overflow <= 1'b0;
            if (rd_inc && rd_empty) underflow <= 1'b1;
            else if (err_clr)       underflow <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rd_data  = mem[rd_ptr[ASIZE-1:0]];
            assign rd_valid = !rd_empty;
        end else begin : g_reg_read
            logic [DSIZE-1:0] rd_data_q;
            logic             rd_valid_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_ok;
                    if (rd_ok) rd_data_q <= mem[rd_ptr[ASIZE-1:0]];
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench: one FWFT and one registered-read FIFO share the same stimulus;
// expected data, counts and flags are hand-derived for the default geometry.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_inc;
    logic       rd_inc;
    logic       err_clr;

    logic [7:0] rd_data_f,  rd_data_r;
    logic       rd_valid_f, rd_valid_r;
    logic       full_f,     full_r;
    logic       empty_f,    empty_r;
    logic       af_f,       af_r;
    logic       ae_f,       ae_r;
    logic [4:0] cnt_f,      cnt_r;
    logic       ovf_f,      ovf_r;
    logic       unf_f,      unf_r;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)) dut_fwft (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_inc(wr_inc), .rd_inc(rd_inc),
        .err_clr(err_clr), .rd_data(rd_data_f), .rd_valid(rd_valid_f), .wr_full(full_f),
        .rd_empty(empty_f), .wr_almost_full(af_f), .rd_almost_empty(ae_f),
        .fill_cnt(cnt_f), .overflow(ovf_f), .underflow(unf_f)
    );

    sync_fifo #(.DSIZE(8), .ASIZE(4), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)) dut_reg (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_inc(wr_inc), .rd_inc(rd_inc),
        .err_clr(err_clr), .rd_data(rd_data_r), .rd_valid(rd_valid_r), .wr_full(full_r),
        .rd_empty(empty_r), .wr_almost_full(af_r), .rd_almost_empty(ae_r),
        .fill_cnt(cnt_r), .overflow(ovf_r), .underflow(unf_r)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given request pattern; outputs are sampled 1 ns after the edge.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d, input logic ec);
        wr_inc  = w;
        rd_inc  = r;
        wr_data = d;
        err_clr = ec;
        @(posedge clk);
        #1;
        wr_inc  = 1'b0;
        rd_inc  = 1'b0;
        err_clr = 1'b0;
    endtask

    // Status flags for a given fill level with AF_LEVEL=14, AE_LEVEL=2, DEPTH=16.
    task automatic check_level(input string tag, input int fill);
        check({tag, " fill_f"},  32'(cnt_f),   32'(fill));
        check({tag, " fill_r"},  32'(cnt_r),   32'(fill));
        check({tag, " empty_f"}, 32'(empty_f), 32'(fill == 0));
        check({tag, " empty_r"}, 32'(empty_r), 32'(fill == 0));
        check({tag, " full_f"},  32'(full_f),  32'(fill == 16));
        check({tag, " full_r"},  32'(full_r),  32'(fill == 16));
        check({tag, " af_f"},    32'(af_f),    32'(fill >= 14));
        check({tag, " ae_f"},    32'(ae_f),    32'(fill <= 2));
        check({tag, " ae_r"},    32'(ae_r),    32'(fill <= 2));
    endtask

    task automatic check_errs(input string tag, input logic ovf, input logic unf);
        check({tag, " ovf_f"}, 32'(ovf_f), 32'(ovf));
        check({tag, " ovf_r"}, 32'(ovf_r), 32'(ovf));
        check({tag, " unf_f"}, 32'(unf_f), 32'(unf));
        check({tag, " unf_r"}, 32'(unf_r), 32'(unf));
    endtask

    // Read one word: FWFT data is checked before the edge, registered data after it.
    task automatic read_word(input string tag, input logic [7:0] exp, input logic w, input logic [7:0] d);
        check({tag, " fwft_data"},  32'(rd_data_f),  32'(exp));
        check({tag, " fwft_valid"}, 32'(rd_valid_f), 32'd1);
        cycle(w, 1'b1, d, 1'b0);
        check({tag, " reg_data"},   32'(rd_data_r),  32'(exp));
        check({tag, " reg_valid"},  32'(rd_valid_r), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; wr_inc = 1'b0; rd_inc = 1'b0; err_clr = 1'b0; wr_data = 8'h00;
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, 8'h77, 1'b1);
        rst = 1'b0;
        check_level("reset", 0);
        check_errs("reset", 1'b0, 1'b0);
        check("reset valid_f", 32'(rd_valid_f), 32'd0);
        check("reset valid_r", 32'(rd_valid_r), 32'd0);
        check("reset data_r",  32'(rd_data_r),  32'd0);

        // Fill to 16 words: 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 8'(i), 1'b0);
            check_level($sformatf("fill%0d", i + 1), i + 1);
        end
        cycle(1'b1, 1'b0, 8'hFF, 1'b0);
        check_level("wr17", 16);
        check_errs("wr17", 1'b1, 1'b0);

        // err_clr coincident with another full-write keeps overflow; alone it clears
        cycle(1'b1, 1'b0, 8'hFE, 1'b1);
        check_errs("clr_vs_set", 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check_errs("clr", 1'b0, 1'b0);
        check_level("clr", 16);

        // Drain 16 words in order
        for (int i = 0; i < 16; i++) begin
            read_word($sformatf("rd%0d", i), 8'(i), 1'b0, 8'h00);
            check_level($sformatf("rd%0d", i), 15 - i);
        end
        check("drained valid_f", 32'(rd_valid_f), 32'd0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("idle valid_r", 32'(rd_valid_r), 32'd0);
        check("idle hold_r",  32'(rd_data_r),  32'h0F);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        check_level("rd17", 0);
        check_errs("rd17", 1'b0, 1'b1);
        check("rd17 valid_r", 32'(rd_valid_r), 32'd0);
        check("rd17 hold_r",  32'(rd_data_r),  32'h0F);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check_errs("clr2", 1'b0, 1'b0);

        // Empty FIFO, write and read together: write wins, read rejected
        cycle(1'b1, 1'b1, 8'h40, 1'b0);
        check_level("empty_both", 1);
        check_errs("empty_both", 1'b0, 1'b1);
        check("empty_both valid_r", 32'(rd_valid_r), 32'd0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1);
        check_errs("clr3", 1'b0, 1'b0);

        // Bring to 5 words, then 40 simultaneous transfers across pointer wrap
        for (int i = 1; i < 5; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
        check_level("pre_stream", 5);
        for (int k = 0; k < 40; k++) begin
            read_word($sformatf("stream%0d", k), 8'(8'h40 + k), 1'b1, 8'(8'h45 + k));
            check($sformatf("stream%0d fill", k), 32'(cnt_f), 32'd5);
        end
        check_level("post_stream", 5);
        check_errs("post_stream", 1'b0, 1'b0);

        // Reset mid-operation at fill 9, with a write request that must be ignored
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h90 + i), 1'b0);
        check_level("pre_rst", 9);
        rst = 1'b1;
        cycle(1'b1, 1'b1, 8'h33, 1'b0);
        rst = 1'b0;
        check_level("mid_rst", 0);
        check_errs("mid_rst", 1'b0, 1'b0);
        check("mid_rst valid_r", 32'(rd_valid_r), 32'd0);
        check("mid_rst data_r",  32'(rd_data_r),  32'd0);
        cycle(1'b1, 1'b0, 8'hA5, 1'b0);
        check_level("a5_wr", 1);
        read_word("a5_rd", 8'hA5, 1'b0, 8'h00);
        check_level("a5_rd", 0);

        // Full FIFO, write and read together: read wins, write rejected
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'hB0 + i), 1'b0);
        check_level("refill", 16);
        read_word("full_both", 8'hB0, 1'b1, 8'hEE);
        check_level("full_both", 15);
        check_errs("full_both", 1'b1, 1'b0);
        for (int i = 1; i < 16; i++) read_word($sformatf("tail%0d", i), 8'(8'hB0 + i), 1'b0, 8'h00);
        check_level("tail_end", 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
